// File: rtl/countdown_timer_if.sv
// Command and display bundle between the timer control logic and the
// countdown engine.
interface countdown_timer_if;
    logic       clear;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] load_min;
    logic [3:0] load_dsec;
    logic [3:0] load_sec;
    logic [3:0] min;
    logic [3:0] dSec;
    logic [3:0] sec;
    logic       running;
    logic       done;

    modport master (
        output clear, load, start, pause, load_min, load_dsec, load_sec,
        input  min, dSec, sec, running, done
    );

    modport slave (
        input  clear, load, start, pause, load_min, load_dsec, load_sec,
        output min, dSec, sec, running, done
    );
endinterface

// File: rtl/countdown_timer.sv
// BCD M:SS countdown engine: loadable up to 9:59, one decrement per CLK_DIV
// cycles while running, with pause/resume, clear and a one-cycle done pulse.
module countdown_timer #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    countdown_timer_if.slave bus
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [3:0]    min_reg, min_next;
    logic [3:0]    dsec_reg, dsec_next;
    logic [3:0]    sec_reg, sec_next;
    logic          running_reg, running_next;
    logic          done_reg, done_next;

    // Load digits clamped to their BCD ceilings: digit 1 is tens-of-seconds.
    logic [3:0] load_raw [3];
    logic [3:0] load_clamped [3];
    assign load_raw[0] = bus.load_sec;
    assign load_raw[1] = bus.load_dsec;
    assign load_raw[2] = bus.load_min;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_clamp
            localparam logic [3:0] LIMIT = (gi == 1) ? 4'd5 : 4'd9;
            assign load_clamped[gi] = (load_raw[gi] > LIMIT) ? LIMIT : load_raw[gi];
        end
    endgenerate

    logic [3:0] dec_min, dec_dsec, dec_sec;
    logic       dec_zero;
    logic       time_zero;

    always_comb begin
        dec_min  = min_reg;
        dec_dsec = dsec_reg;
        dec_sec  = sec_reg;
        if (sec_reg != 4'd0) begin
            dec_sec = sec_reg - 4'd1;
        end else if (dsec_reg != 4'd0) begin
            dec_sec  = 4'd9;
            dec_dsec = dsec_reg - 4'd1;
        end else begin
            dec_sec  = 4'd9;
            dec_dsec = 4'd5;
            dec_min  = min_reg - 4'd1;
        end
    end

    assign dec_zero  = (dec_min == 4'd0) && (dec_dsec == 4'd0) && (dec_sec == 4'd0);
    assign time_zero = (min_reg == 4'd0) && (dsec_reg == 4'd0) && (sec_reg == 4'd0);

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        min_next   = min_reg;
        dsec_next  = dsec_reg;
        sec_next   = sec_reg;
        done_next  = 1'b0;
        // Counting continues in RUN unless pause acts or clear wins; a higher
        // priority command that is ignored in RUN still masks pause.
        if (bus.clear) begin
            state_next = IDLE;
            presc_next = '0;
            min_next   = 4'd0;
            dsec_next  = 4'd0;
            sec_next   = 4'd0;
        end else if (bus.pause && !bus.load && !bus.start && state_reg == RUN) begin
            state_next = PAUSED;
        end else if (bus.load && state_reg != RUN) begin
            state_next = IDLE;
            presc_next = '0;
            min_next   = load_clamped[2];
            dsec_next  = load_clamped[1];
            sec_next   = load_clamped[0];
        end else if (bus.start && !bus.load && state_reg == IDLE && !time_zero) begin
            state_next = RUN;
            presc_next = '0;
        end else if (bus.start && !bus.load && state_reg == PAUSED) begin
            state_next = RUN;
        end else if (state_reg == RUN) begin
            if (presc_reg == PRESC_MAX) begin
                presc_next = '0;
                min_next   = dec_min;
                dsec_next  = dec_dsec;
                sec_next   = dec_sec;
                if (dec_zero) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end
        running_next = (state_next == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            presc_reg   <= '0;
            min_reg     <= 4'd0;
            dsec_reg    <= 4'd0;
            sec_reg     <= 4'd0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            min_reg     <= min_next;
            dsec_reg    <= dsec_next;
            sec_reg     <= sec_next;
            running_reg <= running_next;
            done_reg    <= done_next;
        end
    end

    assign bus.min     = min_reg;
    assign bus.dSec    = dsec_reg;
    assign bus.sec     = sec_reg;
    assign bus.running = running_reg;
    assign bus.done    = done_reg;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table, directed timing
// sequences and a randomized run against a seconds-based reference model.
module tb_countdown_timer;
    localparam int CLK_DIV = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    countdown_timer_if bus();

    countdown_timer #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: remaining time as a plain count of seconds.
    int m_secs  = 0;
    int m_mode  = M_IDLE;
    int m_phase = 0;
    bit m_done  = 0;

    function automatic int clampv(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_count();
        m_phase++;
        if (m_phase == CLK_DIV) begin
            m_phase = 0;
            m_secs--;
            if (m_secs == 0) begin
                m_mode = M_DONE;
                m_done = 1;
            end
        end
    endtask

    task automatic model_step();
        m_done = 0;
        if (!rst_n) begin
            m_secs = 0; m_mode = M_IDLE; m_phase = 0;
        end else if (bus.clear) begin
            m_secs = 0; m_mode = M_IDLE; m_phase = 0;
        end else if (bus.load) begin
            if (m_mode != M_RUN) begin
                m_secs = clampv(int'(bus.load_min), 9) * 60 +
                         clampv(int'(bus.load_dsec), 5) * 10 +
                         clampv(int'(bus.load_sec), 9);
                m_mode = M_IDLE; m_phase = 0;
            end else model_count();
        end else if (bus.start) begin
            if (m_mode == M_IDLE && m_secs != 0) begin
                m_mode = M_RUN; m_phase = 0;
            end else if (m_mode == M_PAUSED) m_mode = M_RUN;
            else if (m_mode == M_RUN) model_count();
        end else if (bus.pause) begin
            if (m_mode == M_RUN) m_mode = M_PAUSED;
        end else if (m_mode == M_RUN) begin
            model_count();
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_out(input string name, input int mn, input int ds, input int s,
                             input int run, input int dn);
        check({name, ".min"}, int'(bus.min), mn);
        check({name, ".dSec"}, int'(bus.dSec), ds);
        check({name, ".sec"}, int'(bus.sec), s);
        check({name, ".running"}, int'(bus.running), run);
        check({name, ".done"}, int'(bus.done), dn);
    endtask

    task automatic idle_cmds();
        bus.clear = 0; bus.load = 0; bus.start = 0; bus.pause = 0;
    endtask

    task automatic do_load(input int mn, input int ds, input int s);
        bus.load = 1; bus.load_min = 4'(mn); bus.load_dsec = 4'(ds); bus.load_sec = 4'(s);
        tick();
        bus.load = 0;
    endtask

    typedef struct {
        logic       clear, load, start, pause;
        logic [3:0] lmin, ldsec, lsec;
        int         emin, edsec, esec, erun, edone;
    } vec_t;

    vec_t vecs[15];

    initial begin
        rst_n = 0;
        idle_cmds();
        bus.load_min = 0; bus.load_dsec = 0; bus.load_sec = 0;

        // clear load start pause | lmin ldsec lsec | min dsec sec run done
        vecs[0]  = '{0, 1, 0, 0, 4'd12, 4'd7, 4'd15, 9, 5, 9, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 4'd0,  4'd0, 4'd0,  0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 1, 0, 4'd0,  4'd0, 4'd0,  0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 4'd0,  4'd0, 4'd0,  0, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 4'd1,  4'd2, 4'd3,  1, 2, 3, 0, 0};
        vecs[5]  = '{0, 0, 1, 0, 4'd0,  4'd0, 4'd0,  1, 2, 3, 1, 0};
        vecs[6]  = '{0, 1, 0, 0, 4'd5,  4'd5, 4'd5,  1, 2, 3, 1, 0};
        vecs[7]  = '{0, 0, 0, 0, 4'd0,  4'd0, 4'd0,  1, 2, 3, 1, 0};
        vecs[8]  = '{0, 0, 0, 0, 4'd0,  4'd0, 4'd0,  1, 2, 3, 1, 0};
        vecs[9]  = '{0, 0, 0, 0, 4'd0,  4'd0, 4'd0,  1, 2, 2, 1, 0};
        vecs[10] = '{0, 0, 0, 1, 4'd0,  4'd0, 4'd0,  1, 2, 2, 0, 0};
        vecs[11] = '{0, 1, 1, 0, 4'd0,  4'd3, 4'd0,  0, 3, 0, 0, 0};
        vecs[12] = '{0, 0, 1, 0, 4'd0,  4'd0, 4'd0,  0, 3, 0, 1, 0};
        vecs[13] = '{1, 1, 1, 0, 4'd4,  4'd4, 4'd4,  0, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 4'd0,  4'd0, 4'd0,  0, 0, 0, 0, 0};

        tick(); tick();
        check_out("reset", 0, 0, 0, 0, 0);
        rst_n = 1;

        for (int i = 0; i < 15; i++) begin
            bus.clear = vecs[i].clear; bus.load = vecs[i].load;
            bus.start = vecs[i].start; bus.pause = vecs[i].pause;
            bus.load_min = vecs[i].lmin; bus.load_dsec = vecs[i].ldsec;
            bus.load_sec = vecs[i].lsec;
            tick();
            idle_cmds();
            check_out($sformatf("vec%0d", i), vecs[i].emin, vecs[i].edsec, vecs[i].esec,
                      vecs[i].erun, vecs[i].edone);
        end

        // 1:05 full countdown with borrow chain and done timing.
        do_load(1, 0, 5);
        bus.start = 1; tick(); bus.start = 0;
        for (int k = 1; k <= 261; k++) begin
            tick();
            if (k == 3)   check_out("run105_k3", 1, 0, 5, 1, 0);
            if (k == 4)   check_out("run105_k4", 1, 0, 4, 1, 0);
            if (k == 8)   check_out("run105_k8", 1, 0, 3, 1, 0);
            if (k == 20)  check_out("run105_k20", 1, 0, 0, 1, 0);
            if (k == 24)  check_out("run105_borrow", 0, 5, 9, 1, 0);
            if (k == 259) check_out("run105_k259", 0, 0, 1, 1, 0);
            if (k == 260) check_out("run105_done", 0, 0, 0, 0, 1);
            if (k == 261) check_out("run105_after", 0, 0, 0, 0, 0);
        end

        // 0:10 with a pause; the resume edge lands mid-second.
        do_load(0, 1, 0);
        bus.start = 1; tick(); bus.start = 0;
        tick(); tick();
        bus.pause = 1;
        for (int k = 0; k < 6; k++) tick();
        bus.pause = 0;
        check_out("pause_frozen", 0, 1, 0, 0, 0);
        bus.start = 1; tick(); bus.start = 0;
        check_out("resume", 0, 1, 0, 1, 0);
        tick();
        check_out("resume_p1", 0, 1, 0, 1, 0);
        tick();
        check_out("resume_dec", 0, 0, 9, 1, 0);
        for (int k = 12; k <= 47; k++) begin
            tick();
            if (k == 46) check_out("pause_k46", 0, 0, 1, 1, 0);
            if (k == 47) check_out("pause_done", 0, 0, 0, 0, 1);
        end

        // Clear on the wrap edge beats the final decrement.
        do_load(0, 0, 1);
        bus.start = 1; tick(); bus.start = 0;
        tick(); tick(); tick();
        bus.clear = 1; tick(); bus.clear = 0;
        check_out("clear_wrap", 0, 0, 0, 0, 0);
        tick();
        check_out("clear_wrap_after", 0, 0, 0, 0, 0);

        // DONE is sticky against start; load exits; reset mid-RUN.
        do_load(0, 0, 1);
        bus.start = 1; tick(); bus.start = 0;
        for (int k = 0; k < 4; k++) tick();
        check_out("done01", 0, 0, 0, 0, 1);
        bus.start = 1; tick(); bus.start = 0;
        check_out("done_start", 0, 0, 0, 0, 0);
        do_load(0, 0, 2);
        check_out("done_load", 0, 0, 2, 0, 0);
        bus.start = 1; tick(); bus.start = 0;
        tick();
        check_out("pre_reset", 0, 0, 2, 1, 0);
        rst_n = 0; tick(); rst_n = 1;
        check_out("reset_run", 0, 0, 0, 0, 0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 4000; k++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            bus.clear     = ($urandom_range(0, 99) < 2);
            bus.load      = ($urandom_range(0, 99) < 4);
            bus.start     = ($urandom_range(0, 99) < 12);
            bus.pause     = ($urandom_range(0, 99) < 6);
            bus.load_min  = 4'($urandom_range(0, 15));
            bus.load_dsec = 4'($urandom_range(0, 15));
            bus.load_sec  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if (bus.load && $urandom_range(0, 1) == 0) begin
                bus.load_min = 0; bus.load_dsec = 0;
            end
            tick();
            check_out($sformatf("rand%0d", k), m_secs / 60, (m_secs % 60) / 10, m_secs % 10,
                      (m_mode == M_RUN) ? 1 : 0, m_done ? 1 : 0);
        end
        rst_n = 1;
        idle_cmds();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
